mips_multicycle_controller: RTL and testbench
=============================================

Name: mips_multicycle_controller

Overview:
Control unit for the 32-bit multicycle MIPS core. It takes op, funct and zero from the datapath and drives the 15-bit control_bus back into it. It combines:
- a main-decoder FSM (one state per instruction phase),
- an ALU decoder,
- PC-enable logic.
It also emits a retire pulse and an illegal-opcode flag for debug and perf counting.

Parameters:
None.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
op  input  6  instr[31:26] from datapath
funct  input  6  instr[5:0] from datapath
zero  input  1  combinational ALU zero flag from datapath
control_bus  output  15  {IorD, MemWrite, IRWrite, PCEn, ALUSrcA, RegWrite, RegDst, MemtoReg, PCSrc[1:0], ALUSrcB[1:0], ALUControl[2:0]}, bit14 = IorD, bit0 = ALUControl[0]
state  output  4  current FSM state encoding (debug)
instr_done  output  1  one-cycle pulse in the last state of each instruction
illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported

Behaviour:
- Clock and reset: single clock domain, clk. reset_n is asynchronous and active-low.
- While reset_n=0:
  - state=FETCH(0), instr_done=0, illegal_op=0.
  - control_bus forced to 15'h0000, so no PC, IR, register or memory write happens during reset.
- After reset release, the first cycle is FETCH.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 are unreachable and return to FETCH on the next edge with control_bus=0.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op: 100011 lw or 101011 sw -> MEMADR; 000000 R-type -> EXECUTE; 000100 beq -> BRANCH; 001000 addi -> ADDIEXEC; 000010 j -> JUMP; any other op -> FETCH, with illegal_op=1 for that DECODE cycle.
  - MEMADR: lw -> MEMRD, sw -> MEMWR.
  - MEMRD->MEMWB.
  - EXECUTE->ALUWB.
  - ADDIEXEC->ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH, with instr_done=1 in that state.
- Control outputs (Moore on state, except PCEn; unlisted signals are 0):
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - DECODE: ALUSrcB=11, ALUOp=00.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEMRD: IorD=1.
  - MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - ALUWB: RegDst=1, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & zero). This is combinational on zero within the same cycle. zero is ignored outside BRANCH.
- ALU decoder (combinational), ALUOp to ALUControl:
  - ALUOp 00 -> 010 (add); 01 -> 110 (sub).
  - ALUOp 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; other funct -> 010.
  - ALUOp 11 is never produced; decode it as 010.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal op 2.
- Reset mid-instruction: control_bus is forced to 0 immediately (asynchronous) and the in-flight instruction is abandoned. After release the FSM restarts at FETCH.
- op and funct are sampled combinationally from the datapath instruction register, which holds them stable from DECODE to the end of the instruction.

Test Plan:
1. Reset: reset_n=0 -> control_bus=15'h0000, state=0. Release -> first cycle control_bus=15'h180A (FETCH), state=0.
2. lw (op=100011): state sequence 0,1,2,3,4. In state 3, IorD=1. In state 4, RegWrite=1 and MemtoReg=1. instr_done pulses only in state 4.
3. R-type slt (op=0, funct=101010): EXECUTE gives ALUControl=111 and ALUSrcA=1. ALUWB gives RegDst=1 and RegWrite=1. Repeat with funct=100101 -> ALUControl=001.
4. beq (op=000100): in BRANCH with zero=1, PCEn=1, PCSrc=01, ALUControl=110. Repeat with zero=0 -> PCEn=0. Both cases return to FETCH after 3 cycles.
5. j (op=000010) -> JUMP: PCSrc=10, PCEn=1. Illegal op=111111 -> illegal_op=1 for one cycle in DECODE, then FETCH, with no RegWrite or MemWrite ever asserted.
6. sw (op=101011) with reset_n pulsed low during MEMADR -> control_bus=0 immediately and MemWrite never asserted. After release, the sequence starts at FETCH.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: main-decoder FSM, ALU decoder and PC-enable logic.
// Control outputs are Moore decodes of the state register, except PCEn, which also uses zero.
module mips_multicycle_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [14:0] control_bus,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal_op
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned BUS_W = 15;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_iord, w_memwrite, w_irwrite, w_pcwrite, w_branch;
    logic        w_alusrca, w_regwrite, w_regdst, w_memtoreg;
    logic [1:0]  w_pcsrc, w_alusrcb, w_aluop;
    logic [2:0]  w_aluctl;
    logic        w_pcen;
    logic        w_done, w_illegal;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore control decode
    always_comb begin
        w_next     = S_FETCH;
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_alusrca  = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_pcsrc    = 2'b00;
        w_alusrcb  = 2'b00;
        w_aluop    = 2'b00;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEXEC;
                    OP_J:         w_next = S_JUMP;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            S_ADDIEXEC: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_next    = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_JUMP: begin
                w_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
            default: begin
                // Unused encodings fall back to FETCH with every control low
                w_next = S_FETCH;
            end
        endcase
    end

    // ALU decoder
    always_comb begin
        w_aluctl = 3'b010;
        case (w_aluop)
            2'b01: w_aluctl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: w_aluctl = 3'b010;
                    6'b100010: w_aluctl = 3'b110;
                    6'b100100: w_aluctl = 3'b000;
                    6'b100101: w_aluctl = 3'b001;
                    6'b101010: w_aluctl = 3'b111;
                    default:   w_aluctl = 3'b010;
                endcase
            end
            default: w_aluctl = 3'b010;
        endcase
    end

    assign w_pcen = w_pcwrite | (w_branch & zero);

    // reset_n gates the bus directly so no write strobe can escape while reset is held
    assign control_bus = reset_n
        ? {w_iord, w_memwrite, w_irwrite, w_pcen, w_alusrca, w_regwrite, w_regdst,
           w_memtoreg, w_pcsrc, w_alusrcb, w_aluctl}
        : BUS_W'(0);

    assign state      = r_state;
    assign instr_done = w_done;
    assign illegal_op = w_illegal;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: walks each instruction class through the FSM
// and compares state, control_bus and the debug pulses against hand-computed values.
module tb_mips_multicycle_controller;

    logic        clk;
    logic        reset_n;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] control_bus;
    logic [3:0]  state;
    logic        instr_done;
    logic        illegal_op;

    int n_vec;
    int n_err;

    mips_multicycle_controller dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .control_bus (control_bus),
        .state       (state),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state, bus and both pulses in one go
    task automatic chk_all(input string tag, input logic [3:0] s, input logic [14:0] bus,
                           input logic done, input logic ill);
        chk({tag, ".state"}, 32'(state), 32'(s));
        chk({tag, ".bus"}, 32'(control_bus), 32'(bus));
        chk({tag, ".done"}, 32'(instr_done), 32'(done));
        chk({tag, ".illegal"}, 32'(illegal_op), 32'(ill));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        op      = 6'b000000;
        funct   = 6'b000000;
        zero    = 1'b0;

        #2;
        chk_all("reset", 4'd0, 15'h0000, 1'b0, 1'b0);
        reset_n = 1'b1;
        #1;
        chk_all("fetch0", 4'd0, 15'h180A, 1'b0, 1'b0);

        // lw
        op = 6'b100011;
        tick(); chk_all("lw.decode", 4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("lw.memadr", 4'd2, 15'h0412, 1'b0, 1'b0);
        tick(); chk_all("lw.memrd",  4'd3, 15'h4002, 1'b0, 1'b0);
        tick(); chk_all("lw.memwb",  4'd4, 15'h0282, 1'b1, 1'b0);
        tick(); chk_all("lw.fetch",  4'd0, 15'h180A, 1'b0, 1'b0);

        // R-type slt
        op = 6'b000000; funct = 6'b101010;
        tick(); chk_all("slt.decode",  4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("slt.execute", 4'd6, 15'h0407, 1'b0, 1'b0);
        tick(); chk_all("slt.aluwb",   4'd7, 15'h0302, 1'b1, 1'b0);
        tick(); chk_all("slt.fetch",   4'd0, 15'h180A, 1'b0, 1'b0);

        // R-type or
        funct = 6'b100101;
        tick(); chk_all("or.decode",  4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("or.execute", 4'd6, 15'h0401, 1'b0, 1'b0);
        funct = 6'b100100;
        #1; chk("and.execute.bus", 32'(control_bus), 32'h0400);
        funct = 6'b100010;
        #1; chk("sub.execute.bus", 32'(control_bus), 32'h0406);
        funct = 6'b111111;
        #1; chk("badfunct.execute.bus", 32'(control_bus), 32'h0402);
        tick(); chk_all("or.aluwb",   4'd7, 15'h0302, 1'b1, 1'b0);
        tick(); chk_all("or.fetch",   4'd0, 15'h180A, 1'b0, 1'b0);

        // beq taken, then zero dropped within BRANCH
        op = 6'b000100; zero = 1'b1;
        tick(); chk_all("beq1.decode", 4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("beq1.branch", 4'd8, 15'h0C26, 1'b1, 1'b0);
        zero = 1'b0;
        #1; chk("beq1.branch.zero0", 32'(control_bus), 32'h0426);
        tick(); chk_all("beq1.fetch",  4'd0, 15'h180A, 1'b0, 1'b0);

        // beq not taken; zero high outside BRANCH must not matter
        zero = 1'b1;
        tick(); chk_all("beq0.decode", 4'd1, 15'h001A, 1'b0, 1'b0);
        zero = 1'b0;
        tick(); chk_all("beq0.branch", 4'd8, 15'h0426, 1'b1, 1'b0);
        zero = 1'b1;
        tick(); chk_all("beq0.fetch",  4'd0, 15'h180A, 1'b0, 1'b0);
        zero = 1'b0;

        // j
        op = 6'b000010;
        tick(); chk_all("j.decode", 4'd1,  15'h001A, 1'b0, 1'b0);
        tick(); chk_all("j.jump",   4'd11, 15'h0842, 1'b1, 1'b0);
        tick(); chk_all("j.fetch",  4'd0,  15'h180A, 1'b0, 1'b0);

        // illegal opcode
        op = 6'b111111;
        tick(); chk_all("ill.decode", 4'd1, 15'h001A, 1'b0, 1'b1);
        tick(); chk_all("ill.fetch",  4'd0, 15'h180A, 1'b0, 1'b0);

        // addi
        op = 6'b001000;
        tick(); chk_all("addi.decode", 4'd1,  15'h001A, 1'b0, 1'b0);
        tick(); chk_all("addi.exec",   4'd9,  15'h0412, 1'b0, 1'b0);
        tick(); chk_all("addi.wb",     4'd10, 15'h0202, 1'b1, 1'b0);
        tick(); chk_all("addi.fetch",  4'd0,  15'h180A, 1'b0, 1'b0);

        // sw interrupted by reset in MEMADR
        op = 6'b101011;
        tick(); chk_all("swr.decode", 4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("swr.memadr", 4'd2, 15'h0412, 1'b0, 1'b0);
        #2; reset_n = 1'b0;
        #1; chk_all("swr.inreset", 4'd0, 15'h0000, 1'b0, 1'b0);
        tick(); chk_all("swr.heldreset", 4'd0, 15'h0000, 1'b0, 1'b0);
        #2; reset_n = 1'b1;
        #1; chk_all("swr.release", 4'd0, 15'h180A, 1'b0, 1'b0);

        // complete sw after reset
        tick(); chk_all("sw.decode", 4'd1, 15'h001A, 1'b0, 1'b0);
        tick(); chk_all("sw.memadr", 4'd2, 15'h0412, 1'b0, 1'b0);
        tick(); chk_all("sw.memwr",  4'd5, 15'h6002, 1'b1, 1'b0);
        tick(); chk_all("sw.fetch",  4'd0, 15'h180A, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
